// File: rtl/pair_match_ctrl.sv
// ---------------------------------------------------------------------------
// pair_match_ctrl
//
// Grid controller for the pair-matching game. Tracks a cursor over a
// ROWS x COLS board, lets the player pick two cards, fetches both tile IDs
// from an external board ROM, and either removes the pair (match) or blinks
// it for BLINK_CYC cycles before deselecting (mismatch).
//
// Build option:
//   CURSOR_WRAP_EN  - when defined, cursor moves past an edge wrap to the
//                     opposite row/column; otherwise the cursor saturates.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   up/down/left/right       single-cycle move pulses (priority in that order)
//   s                        single-cycle select pulse
//   tile_addr  [IW-1:0]      registered board ROM address
//   tile_id    [ID_W-1:0]    board ROM data, valid one cycle after tile_addr
//   cur_bus    [N-1:0]       one-hot cursor, bit = row*COLS+col
//   sel_bus    [N-1:0]       currently selected cards
//   hidden_bus [N-1:0]       matched/removed cards
//   blink_bus  [N-1:0]       cards blinking after a mismatch
//   ms / mf                  one-cycle match-success / match-fail pulses
//   pair_cnt   [IW-1:0]      matched pairs since reset (saturates at N/2)
//   all_clear                sticky flag, set when pair_cnt reaches N/2
// ---------------------------------------------------------------------------
module pair_match_ctrl #(
    parameter int ROWS      = 6,
    parameter int COLS      = 6,
    parameter int ID_W      = 8,
    parameter int BLINK_CYC = 50000000,
    localparam int N        = ROWS * COLS,
    localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            up,
    input  logic            down,
    input  logic            left,
    input  logic            right,
    input  logic            s,
    output logic [IW-1:0]   tile_addr,
    input  logic [ID_W-1:0] tile_id,
    output logic [N-1:0]    cur_bus,
    output logic [N-1:0]    sel_bus,
    output logic [N-1:0]    hidden_bus,
    output logic [N-1:0]    blink_bus,
    output logic            ms,
    output logic            mf,
    output logic [IW-1:0]   pair_cnt,
    output logic            all_clear
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNT_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam int HALF  = N / 2;

    localparam logic [RW-1:0]    ROW_MAX  = RW'(ROWS - 1);
    localparam logic [CW-1:0]    COL_MAX  = CW'(COLS - 1);
    localparam logic [N-1:0]     ONE_HOT0 = N'(1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BLINK_CYC - 1);

`ifdef CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE,
        SEL1,
        FETCH_A,
        FETCH_B,
        COMPARE,
        BLINK
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [RW-1:0]    r_row;
    logic [CW-1:0]    r_col;
    logic [IW-1:0]    r_idx_a;
    logic [IW-1:0]    r_idx_b;
    logic [ID_W-1:0]  r_id_a;
    logic [IW-1:0]    r_tile_addr;
    logic [N-1:0]     r_sel;
    logic [N-1:0]     r_hidden;
    logic [N-1:0]     r_blink;
    logic [CNT_W-1:0] r_blink_cnt;
    logic             r_ms;
    logic             r_mf;
    logic [IW-1:0]    r_pair_cnt;
    logic             r_all_clear;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic [RW-1:0] w_row_nxt;
    logic [CW-1:0] w_col_nxt;
    logic [IW-1:0] w_cur_idx;
    logic [N-1:0]  w_cur_bus;
    logic [N-1:0]  w_bit_a;
    logic [N-1:0]  w_bit_b;
    logic          w_cur_hidden;
    logic          w_ids_equal;

    // FSM control strobes
    logic w_sel_a;
    logic w_desel_a;
    logic w_sel_b;
    logic w_addr_a;
    logic w_addr_b;
    logic w_match;
    logic w_mismatch;
    logic w_cnt_dec;
    logic w_blink_end;

    // Cursor index and decoded masks; selection always uses the registered
    // (pre-move) cursor, so a move in the same cycle does not affect it.
    always_comb begin
        w_cur_idx    = IW'(int'(r_row) * COLS + int'(r_col));
        w_cur_bus    = ONE_HOT0 << w_cur_idx;
        w_bit_a      = ONE_HOT0 << r_idx_a;
        w_bit_b      = ONE_HOT0 << r_idx_b;
        w_cur_hidden = |(r_hidden & w_cur_bus);
        w_ids_equal  = (r_id_a == tile_id);
    end

    // Cursor movement: one move per cycle, up > down > left > right.
    always_comb begin
        w_row_nxt = r_row;
        w_col_nxt = r_col;
        if (up) begin
            if (r_row != '0) begin
                w_row_nxt = r_row - RW'(1);
            end else if (WRAP) begin
                w_row_nxt = ROW_MAX;
            end
        end else if (down) begin
            if (r_row != ROW_MAX) begin
                w_row_nxt = r_row + RW'(1);
            end else if (WRAP) begin
                w_row_nxt = '0;
            end
        end else if (left) begin
            if (r_col != '0) begin
                w_col_nxt = r_col - CW'(1);
            end else if (WRAP) begin
                w_col_nxt = COL_MAX;
            end
        end else if (right) begin
            if (r_col != COL_MAX) begin
                w_col_nxt = r_col + CW'(1);
            end else if (WRAP) begin
                w_col_nxt = '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and control strobes
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_sel_a     = 1'b0;
        w_desel_a   = 1'b0;
        w_sel_b     = 1'b0;
        w_addr_a    = 1'b0;
        w_addr_b    = 1'b0;
        w_match     = 1'b0;
        w_mismatch  = 1'b0;
        w_cnt_dec   = 1'b0;
        w_blink_end = 1'b0;

        case (r_state)
            IDLE: begin
                if (s && !w_cur_hidden) begin
                    w_sel_a     = 1'b1;
                    w_state_nxt = SEL1;
                end
            end

            SEL1: begin
                if (s) begin
                    if (w_cur_idx == r_idx_a) begin
                        w_desel_a   = 1'b1;
                        w_state_nxt = IDLE;
                    end else if (!w_cur_hidden) begin
                        w_sel_b     = 1'b1;
                        w_state_nxt = FETCH_A;
                    end
                end
            end

            FETCH_A: begin
                w_addr_a    = 1'b1;
                w_state_nxt = FETCH_B;
            end

            // Captures idA from the address set in FETCH_A and launches idxB.
            FETCH_B: begin
                w_addr_b    = 1'b1;
                w_state_nxt = COMPARE;
            end

            // idB is compared straight off tile_id on this edge.
            COMPARE: begin
                if (w_ids_equal) begin
                    w_match     = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_mismatch  = 1'b1;
                    w_state_nxt = BLINK;
                end
            end

            BLINK: begin
                if (r_blink_cnt == '0) begin
                    w_blink_end = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row       <= '0;
            r_col       <= '0;
            r_idx_a     <= '0;
            r_idx_b     <= '0;
            r_id_a      <= '0;
            r_tile_addr <= '0;
            r_sel       <= '0;
            r_hidden    <= '0;
            r_blink     <= '0;
            r_blink_cnt <= '0;
            r_ms        <= 1'b0;
            r_mf        <= 1'b0;
            r_pair_cnt  <= '0;
            r_all_clear <= 1'b0;
        end else begin
            r_row <= w_row_nxt;
            r_col <= w_col_nxt;
            r_ms  <= w_match;
            r_mf  <= w_mismatch;

            if (w_sel_a) begin
                r_idx_a <= w_cur_idx;
                r_sel   <= r_sel | w_cur_bus;
            end

            if (w_desel_a) begin
                r_sel <= r_sel & ~w_bit_a;
            end

            if (w_sel_b) begin
                r_idx_b <= w_cur_idx;
                r_sel   <= r_sel | w_cur_bus;
            end

            if (w_addr_a) begin
                r_tile_addr <= r_idx_a;
            end

            if (w_addr_b) begin
                r_id_a      <= tile_id;
                r_tile_addr <= r_idx_b;
            end

            if (w_match) begin
                r_hidden <= r_hidden | w_bit_a | w_bit_b;
                r_sel    <= '0;
                if (int'(r_pair_cnt) < HALF) begin
                    r_pair_cnt <= r_pair_cnt + IW'(1);
                end
                if (int'(r_pair_cnt) + 1 == HALF) begin
                    r_all_clear <= 1'b1;
                end
            end

            if (w_mismatch) begin
                r_blink     <= w_bit_a | w_bit_b;
                r_blink_cnt <= CNT_INIT;
            end

            if (w_cnt_dec) begin
                r_blink_cnt <= r_blink_cnt - CNT_W'(1);
            end

            if (w_blink_end) begin
                r_blink <= '0;
                r_sel   <= '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign tile_addr  = r_tile_addr;
    assign cur_bus    = w_cur_bus;
    assign sel_bus    = r_sel;
    assign hidden_bus = r_hidden;
    assign blink_bus  = r_blink;
    assign ms         = r_ms;
    assign mf         = r_mf;
    assign pair_cnt   = r_pair_cnt;
    assign all_clear  = r_all_clear;

endmodule
